dmem_responder: RTL and testbench

- Memory-side responder for the core's data-memory port. The core's MEM stage is the initiator; this block answers its load/store requests.
- Accepts one request at a time over a valid/ready handshake.
- Supports byte, halfword and word accesses with configurable wait states.
- Returns sign- or zero-extended load data, or an error flag, as a single-cycle response pulse.

---
 rtl/dmem_pkg.sv | 64 ++++++
 rtl/dmem_bram.sv | 26 ++
 rtl/dmem_responder.sv | 167 ++++++++++++++++
 tb/tb_dmem_responder.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared encodings, FSM states and lane helpers for dmem_responder.
// The CLEAR state exists only when DMEM_CLEAR_EN is defined.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

`ifdef DMEM_CLEAR_EN
  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP, ST_CLEAR} state_t;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;
`endif

  typedef struct packed {
    logic [3:0]  be;
    logic [31:0] data;
  } wr_t;

  function automatic logic [31:0] load_extend(input logic [1:0]  size,
                                              input logic        is_unsigned,
                                              input logic [1:0]  lane,
                                              input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = lane[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_BYTE: res = {{24{~is_unsigned & b[7]}}, b};
      SZ_HALF: res = {{16{~is_unsigned & h[15]}}, h};
      default: res = word;
    endcase
    return res;
  endfunction

  // Data is replicated across lanes so only the byte enables depend on the address.
  function automatic wr_t store_merge(input logic [1:0]  size,
                                      input logic [1:0]  lane,
                                      input logic [31:0] wdata);
    wr_t w;
    w.be   = 4'b0000;
    w.data = wdata;
    case (size)
      SZ_BYTE: begin
        w.be   = 4'b0001 << lane;
        w.data = {4{wdata[7:0]}};
      end
      SZ_HALF: begin
        w.be   = lane[1] ? 4'b1100 : 4'b0011;
        w.data = {2{wdata[15:0]}};
      end
      SZ_WORD: w.be = 4'b1111;
      default: w.be = 4'b0000;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/dmem_bram.sv
// DEPTH x 32 storage with per-byte write enables and registered read data.
// One access per cycle when en is high; read returns the pre-write contents.
module dmem_bram #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          en,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder; response pulses WAIT_CYCLES+1 cycles after accept, no rsp backpressure.
// req_ready is low from accept until the response; DMEM_CLEAR_EN adds a post-reset zeroing sweep.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int          AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [32:0] BYTE_LIMIT = 33'(DEPTH) * 33'd4;
  localparam logic [3:0]  WAIT_LAST  = 4'(WAIT_CYCLES);
`ifdef DMEM_CLEAR_EN
  localparam state_t      RESET_STATE = ST_CLEAR;
`else
  localparam state_t      RESET_STATE = ST_IDLE;
`endif

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          we_q, we_d, uns_q, uns_d, err_q, err_d;
  logic [1:0]    size_q, size_d, lane_q, lane_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [31:0]   wdata_q, wdata_d;
`ifdef DMEM_CLEAR_EN
  logic [AW-1:0] clr_q, clr_d;
`endif

  logic          enter_resp;
  logic          req_err;
  wr_t           wr;
  logic          mem_en;
  logic [3:0]    mem_be;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata, mem_rdata;

  assign req_err = (req_size == 2'b11)
                || (req_size == SZ_HALF && req_addr[0])
                || (req_size == SZ_WORD && req_addr[1:0] != 2'b00)
                || ({1'b0, req_addr} >= BYTE_LIMIT);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    we_d       = we_q;
    size_d     = size_q;
    uns_d      = uns_q;
    lane_d     = lane_q;
    idx_d      = idx_q;
    wdata_d    = wdata_q;
    err_d      = err_q;
    enter_resp = 1'b0;
`ifdef DMEM_CLEAR_EN
    clr_d      = clr_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          size_d  = req_size;
          uns_d   = req_unsigned;
          lane_d  = req_addr[1:0];
          idx_d   = req_addr[AW+1:2];
          wdata_d = req_wdata;
          err_d   = req_err;
          if (WAIT_CYCLES == 0) begin
            state_d    = ST_RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = 4'd1;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == WAIT_LAST) begin
          state_d    = ST_RESP;
          enter_resp = 1'b1;
          cnt_d      = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
`ifdef DMEM_CLEAR_EN
      ST_CLEAR: begin
        if (clr_q == AW'(DEPTH - 1)) state_d = ST_IDLE;
        else                         clr_d   = clr_q + AW'(1);
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // The _d copies of the request equal the live inputs on a zero-wait accept and
  // the latched request otherwise, so one port mux serves both cases.
  always_comb begin
    wr        = store_merge(size_d, lane_d, wdata_d);
    mem_en    = enter_resp & ~RST;
    mem_addr  = idx_d;
    mem_wdata = wr.data;
    mem_be    = (we_d & ~err_d) ? wr.be : 4'b0000;
`ifdef DMEM_CLEAR_EN
    if (state_q == ST_CLEAR) begin
      mem_en    = ~RST;
      mem_addr  = clr_q;
      mem_wdata = 32'h0;
      mem_be    = 4'b1111;
    end
`endif
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= RESET_STATE;
      cnt_q   <= 4'd0;
`ifdef DMEM_CLEAR_EN
      clr_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
`ifdef DMEM_CLEAR_EN
      clr_q   <= clr_d;
`endif
    end
  end

  always_ff @(posedge CLK) begin
    we_q    <= we_d;
    size_q  <= size_d;
    uns_q   <= uns_d;
    lane_q  <= lane_d;
    idx_q   <= idx_d;
    wdata_q <= wdata_d;
    err_q   <= err_d;
  end

  dmem_bram #(.DEPTH(DEPTH), .AW(AW)) u_bram (
    .clk   (CLK),
    .en    (mem_en),
    .be    (mem_be),
    .addr  (mem_addr),
    .wdata (mem_wdata),
    .rdata (mem_rdata)
  );

  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_err   = rsp_valid & err_q;
  assign rsp_rdata = (rsp_valid && !we_q && !err_q)
                   ? load_extend(size_q, uns_q, lane_q, mem_rdata) : 32'h0;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: byte-addressed reference memory, directed and random traffic.
module tb_dmem_responder;

  localparam int DEPTH    = 256;
  localparam int WAIT_CYC = 1;
  localparam int NBYTES   = DEPTH * 4;

  logic        CLK = 1'b0;
  logic        RST;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;

  typedef struct {
    logic [31:0] rd;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t       exp_q[$];
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  int         stall = 0;
  logic [7:0] mdl [NBYTES];
  logic       chk_rst = 1'b0;
  logic       end_chk = 1'b0;
  logic       clr_chk = 1'b0;
  logic       rst_ready_exp;
  int         clr_meas = 0;

  dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(WAIT_CYC)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  // Monitor: every comparison of the run happens here.
  always @(negedge CLK) begin
    exp_t e;
    if (rsp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_rsp: rsp_valid=1 at cycle %0d, required no response", cyc);
      end else begin
        e = exp_q.pop_front();
        checks++;
        if (rsp_rdata !== e.rd) begin
          errors++;
          $display("FAIL rsp_rdata: got %h required %h", rsp_rdata, e.rd);
        end
        checks++;
        if (rsp_err !== e.err) begin
          errors++;
          $display("FAIL rsp_err: got %b required %b", rsp_err, e.err);
        end
        checks++;
        if (cyc != e.cyc) begin
          errors++;
          $display("FAIL rsp_latency: response at cycle %0d required %0d", cyc, e.cyc);
        end
      end
    end
    if (chk_rst) begin
      checks++;
      if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
        errors++;
        $display("FAIL reset_outputs: got valid=%b rdata=%h err=%b required 0/0/0",
                 rsp_valid, rsp_rdata, rsp_err);
      end
      checks++;
      if (req_ready !== rst_ready_exp) begin
        errors++;
        $display("FAIL reset_ready: got %b required %b", req_ready, rst_ready_exp);
      end
    end
    if (clr_chk) begin
      checks++;
      if (clr_meas != DEPTH) begin
        errors++;
        $display("FAIL clear_length: req_ready low for %0d cycles required %0d", clr_meas, DEPTH);
      end
    end
    if (end_chk) begin
      checks++;
      if (exp_q.size() != 0) begin
        errors++;
        $display("FAIL missing_rsp: %0d responses outstanding, required 0", exp_q.size());
      end
    end
    if (req_valid === 1'b1 && req_ready !== 1'b1) stall++;
    else stall = 0;
    if (stall == 60) begin
      checks++; errors++;
      $display("FAIL handshake_timeout: req_ready=%b for 60 cycles, required 1", req_ready);
    end
  end

  // Reference: little-endian byte array, accesses applied in issue order.
  task automatic model_access(input logic we, input logic [1:0] size, input logic uns,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              output logic err, output logic [31:0] rd);
    int n;
    logic [31:0] v;
    n   = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    err = (size == 2'd3) || (addr % n != 0) || (addr >= NBYTES);
    rd  = 32'h0;
    if (!err) begin
      if (we) begin
        for (int i = 0; i < n; i++) mdl[addr + i] = wdata[8*i +: 8];
      end else begin
        v = 32'h0;
        for (int i = 0; i < n; i++) v = v | (32'(mdl[addr + i]) << (8 * i));
        if (!uns && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
        rd = v;
      end
    end
  endtask

  // mode 0: expect model result; mode 1: expect given constants; mode 2: no response expected.
  task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input int mode, input logic [31:0] c_rd, input logic c_err);
    int          w;
    exp_t        e;
    logic        m_err;
    logic [31:0] m_rd;
    @(negedge CLK);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    w = 0;
    while (req_ready !== 1'b1 && w < 80) begin
      @(negedge CLK);
      w++;
    end
    if (req_ready === 1'b1) begin
      if (mode != 2) begin
        model_access(we, size, uns, addr, wdata, m_err, m_rd);
        e.rd  = (mode == 1) ? c_rd  : m_rd;
        e.err = (mode == 1) ? c_err : m_err;
        e.cyc = cyc + 1 + WAIT_CYC;
        exp_q.push_back(e);
      end
      @(posedge CLK);
      #1;
    end
    req_valid = 1'b0;
    req_we = 1'($urandom); req_size = 2'($urandom); req_unsigned = 1'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
  endtask

  // Called at a point just after a rising edge; RST is raised immediately.
  task automatic apply_reset(input int ncyc);
    int n;
    RST = 1'b1;
    repeat (ncyc) @(posedge CLK);
    #1;
    RST = 1'b0;
    chk_rst = 1'b1;
    @(negedge CLK);
    #1 chk_rst = 1'b0;
    n = 0;
    while (req_ready !== 1'b1 && n < 4 * DEPTH) begin
      n++;
      @(negedge CLK);
      #1;
    end
`ifdef DMEM_CLEAR_EN
    clr_meas = n;
    clr_chk  = 1'b1;
    @(negedge CLK);
    #1 clr_chk = 1'b0;
    for (int i = 0; i < NBYTES; i++) mdl[i] = 8'h00;
`endif
  endtask

  initial begin
    int w;
    logic [1:0]  sz;
    logic [31:0] ad;
    RST = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
`ifdef DMEM_CLEAR_EN
    rst_ready_exp = 1'b0;
`else
    rst_ready_exp = 1'b1;
`endif
    apply_reset(3);

    for (int a = 0; a < DEPTH; a++) do_req(1'b1, 2'b10, 1'b0, 32'(a * 4), $urandom, 0, 32'h0, 1'b0);

    do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 1, 32'h0, 1'b0);
    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1, 32'hDEADBEEF, 1'b0);
    do_req(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 1, 32'hFFFFFFDE, 1'b0);
    do_req(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 1, 32'h000000DE, 1'b0);
    do_req(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 1, 32'hFFFFDEAD, 1'b0);
    do_req(1'b0, 2'b01, 1'b1, 32'h10, 32'h0, 1, 32'h0000BEEF, 1'b0);
    do_req(1'b1, 2'b00, 1'b0, 32'h11, 32'h00000055, 1, 32'h0, 1'b0);
    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1, 32'hDEAD55EF, 1'b0);
    do_req(1'b0, 2'b10, 1'b0, 32'h12, 32'h0, 1, 32'h0, 1'b1);
    do_req(1'b1, 2'b01, 1'b0, 32'h11, 32'h0000AAAA, 1, 32'h0, 1'b1);
    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1, 32'hDEAD55EF, 1'b0);
    do_req(1'b0, 2'b10, 1'b0, 32'h400, 32'h0, 1, 32'h0, 1'b1);
    do_req(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 1, 32'h0, 1'b1);
    do_req(1'b1, 2'b10, 1'b0, 32'h400, 32'h12345678, 1, 32'h0, 1'b1);

    // Store dropped by a reset landing in its wait cycle.
    do_req(1'b1, 2'b10, 1'b0, 32'h20, 32'h1, 2, 32'h0, 1'b0);
    apply_reset(1);
    do_req(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 0, 32'h0, 1'b0);

    for (int k = 0; k < 400; k++) begin
      sz = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      if ($urandom_range(0, 9) == 0) ad = 32'(NBYTES) + 32'($urandom_range(0, 4095));
      else                           ad = 32'($urandom_range(0, NBYTES - 1));
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'b01)      ad[0]   = 1'b0;
        else if (sz == 2'b10) ad[1:0] = 2'b00;
      end
      do_req(1'($urandom), sz, 1'($urandom), ad, $urandom, 0, 32'h0, 1'b0);
      repeat ($urandom_range(0, 2)) @(negedge CLK);
    end

    w = 0;
    while (exp_q.size() != 0 && w < 100) begin
      @(negedge CLK);
      w++;
    end
    @(posedge CLK);
    #1 end_chk = 1'b1;
    @(negedge CLK);
    #1 end_chk = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
